// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read-channel arbiter.
//   - arb_state_e : sequencer states (IDLE, ADDR, DATA)
//   - SEL_S0..SEL_S5, SEL_DEF : slave select encodings (SEL_DEF = decode error)
//   - Sx_BASE / Sx_LIMIT : inclusive address window of each slave
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0] SEL_S0  = 3'd0;
  localparam logic [2:0] SEL_S1  = 3'd1;
  localparam logic [2:0] SEL_S2  = 3'd2;
  localparam logic [2:0] SEL_S3  = 3'd3;
  localparam logic [2:0] SEL_S4  = 3'd4;
  localparam logic [2:0] SEL_S5  = 3'd5;
  localparam logic [2:0] SEL_DEF = 3'd6;

  localparam logic [31:0] S0_BASE  = 32'h0000_0000;  // ROM
  localparam logic [31:0] S0_LIMIT = 32'h0000_3FFF;
  localparam logic [31:0] S1_BASE  = 32'h0001_0000;
  localparam logic [31:0] S1_LIMIT = 32'h0001_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h0002_0000;
  localparam logic [31:0] S2_LIMIT = 32'h0002_FFFF;
  localparam logic [31:0] S3_BASE  = 32'h1000_0000;
  localparam logic [31:0] S3_LIMIT = 32'h1000_03FF;
  localparam logic [31:0] S4_BASE  = 32'h1001_0000;
  localparam logic [31:0] S4_LIMIT = 32'h1001_03FF;
  localparam logic [31:0] S5_BASE  = 32'h2000_0000;  // DRAM
  localparam logic [31:0] S5_LIMIT = 32'h201F_FFFF;

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational address decoder: maps a read address onto one of six slave
// windows, or onto the default (decode-error) slave when no window matches.
// Ports:
//   addr      in  ADDR_BITS  address to decode
//   slave_sel out 3          0..5 = S0..S5, 6 = default slave
module axi_addr_decoder #(
  parameter int ADDR_BITS = 32
) (
  input  logic [ADDR_BITS-1:0] addr,
  output logic [2:0]           slave_sel
);
  import axi_arb_pkg::*;

  // Windows are 32-bit; widen everything so narrower or wider address buses
  // compare correctly (bits above 31 must be zero to hit any window).
  function automatic logic in_window(input logic [63:0] a,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (a >= {32'd0, lo}) && (a <= {32'd0, hi});
  endfunction

  logic [63:0] addr_w;

  always_comb begin
    addr_w    = 64'(addr);
    slave_sel = SEL_DEF;
    if      (in_window(addr_w, S0_BASE, S0_LIMIT)) slave_sel = SEL_S0;
    else if (in_window(addr_w, S1_BASE, S1_LIMIT)) slave_sel = SEL_S1;
    else if (in_window(addr_w, S2_BASE, S2_LIMIT)) slave_sel = SEL_S2;
    else if (in_window(addr_w, S3_BASE, S3_LIMIT)) slave_sel = SEL_S3;
    else if (in_window(addr_w, S4_BASE, S4_LIMIT)) slave_sel = SEL_S4;
    else if (in_window(addr_w, S5_BASE, S5_LIMIT)) slave_sel = SEL_S5;
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-channel arbiter/sequencer for the AXI bridge. Two masters (M0 = fetch,
// M1 = data) share one read path with round-robin priority on ties. The grant
// and decoded slave select are held from the AR request until the RLAST
// handshake, after which IDLE is visited for at least one bubble cycle.
// Optional feature macro: AXI_RD_ARB_TIMEOUT_EN (read-data timeout).
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   ARVALID_M0/M1, ARADDR_*  read requests from the two masters
//   ARREADY_SEL              ARREADY of the currently selected slave
//   RVALID_SEL, RLAST_SEL    R channel of the selected slave
//   RREADY_SEL               RREADY of the granted master
//   grant                    one-hot grant (bit0 = M0, bit1 = M1)
//   slave_sel                0..5 = S0..S5, 6 = default slave
//   busy                     sequencer not IDLE
//   timeout                  one-cycle pulse on read timeout (0 when disabled)
module axi_read_arbiter #(
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_BITS       = 10
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 ARVALID_M0,
  input  logic                 ARVALID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic                 ARREADY_SEL,
  input  logic                 RVALID_SEL,
  input  logic                 RREADY_SEL,
  input  logic                 RLAST_SEL,
  output logic [1:0]           grant,
  output logic [2:0]           slave_sel,
  output logic                 busy,
  output logic                 timeout
);
  import axi_arb_pkg::*;

  arb_state_e           state;
  logic                 last_m1;   // last grant went to M1
  logic                 pick_m1;
  logic [ADDR_BITS-1:0] win_addr;
  logic [2:0]           dec_sel;
  logic                 ar_granted;
  logic                 r_hs;

  // On a tie the master that did not win last time takes the path.
  assign pick_m1    = ARVALID_M1 && (!ARVALID_M0 || !last_m1);
  assign win_addr   = pick_m1 ? ARADDR_M1 : ARADDR_M0;
  assign ar_granted = grant[0] ? ARVALID_M0 : ARVALID_M1;
  assign r_hs       = RVALID_SEL && RREADY_SEL;

  axi_addr_decoder #(.ADDR_BITS(ADDR_BITS)) u_dec (
    .addr      (win_addr),
    .slave_sel (dec_sel)
  );

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam logic [CNT_BITS-1:0] TO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  logic [CNT_BITS-1:0] cnt;
`else
  // Without the timeout feature the timer parameters have no effect.
  if (TIMEOUT_CYCLES > 0 && CNT_BITS > 0) begin : g_no_timeout
    assign timeout = 1'b0;
  end else begin : g_no_timeout_cfg
    assign timeout = 1'b0;
  end
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant     <= 2'b00;
      slave_sel <= SEL_DEF;
      busy      <= 1'b0;
      last_m1   <= 1'b1;   // M0 wins the first tie
`ifdef AXI_RD_ARB_TIMEOUT_EN
      timeout   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
`ifdef AXI_RD_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ARVALID_M0 || ARVALID_M1) begin
            state     <= ADDR;
            grant     <= pick_m1 ? 2'b10 : 2'b01;
            slave_sel <= dec_sel;
            busy      <= 1'b1;
            last_m1   <= pick_m1;
          end
        end
        // A dropped ARVALID simply leaves us waiting here.
        ADDR: begin
          if (ar_granted && ARREADY_SEL) begin
            state <= DATA;
`ifdef AXI_RD_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        DATA: begin
          if (r_hs && RLAST_SEL) begin
            state     <= IDLE;
            grant     <= 2'b00;
            slave_sel <= SEL_DEF;
            busy      <= 1'b0;
          end
`ifdef AXI_RD_ARB_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state     <= IDLE;
            grant     <= 2'b00;
            slave_sel <= SEL_DEF;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end else if (r_hs) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          grant     <= 2'b00;
          slave_sel <= SEL_DEF;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: a transaction-level model tracks who owns the
// read path and which slave the address selects; every falling clock edge the
// DUT outputs are compared with it. Directed scenarios add literal checks.
module tb_axi_read_arbiter;

  localparam int TB_TO = 8;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        ARVALID_M0 = 1'b0;
  logic        ARVALID_M1 = 1'b0;
  logic [31:0] ARADDR_M0 = 32'd0;
  logic [31:0] ARADDR_M1 = 32'd0;
  logic        ARREADY_SEL = 1'b0;
  logic        RVALID_SEL = 1'b0;
  logic        RREADY_SEL = 1'b0;
  logic        RLAST_SEL = 1'b0;
  logic [1:0]  grant;
  logic [2:0]  slave_sel;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  axi_read_arbiter #(.ADDR_BITS(32), .TIMEOUT_CYCLES(TB_TO), .CNT_BITS(10)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .ARVALID_M0  (ARVALID_M0),
    .ARVALID_M1  (ARVALID_M1),
    .ARADDR_M0   (ARADDR_M0),
    .ARADDR_M1   (ARADDR_M1),
    .ARREADY_SEL (ARREADY_SEL),
    .RVALID_SEL  (RVALID_SEL),
    .RREADY_SEL  (RREADY_SEL),
    .RLAST_SEL   (RLAST_SEL),
    .grant       (grant),
    .slave_sel   (slave_sel),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Address map straight from the slave list.
  function automatic int map_addr(input logic [31:0] a);
    if (a <= 32'h0000_3FFF) return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
    if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3;
    if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) return 4;
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 5;
    return 6;
  endfunction

  // Model: owner = -1 (nobody) / 0 / 1; phase 0 = waiting for a request,
  // 1 = address phase, 2 = data phase.
  int m_owner, m_phase, m_sel, m_cnt, m_win;
  bit m_last1, m_to;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_owner <= -1; m_phase <= 0; m_sel <= 6; m_last1 <= 1'b1; m_to <= 1'b0; m_cnt <= 0;
    end else begin
      m_to <= 1'b0;
      if (m_phase == 0) begin
        if (ARVALID_M0 || ARVALID_M1) begin
          if (ARVALID_M0 && ARVALID_M1) m_win = m_last1 ? 0 : 1;
          else m_win = ARVALID_M1 ? 1 : 0;
          m_owner <= m_win;
          m_phase <= 1;
          m_sel   <= map_addr(m_win == 1 ? ARADDR_M1 : ARADDR_M0);
          m_last1 <= (m_win == 1);
        end
      end else if (m_phase == 1) begin
        if ((m_owner == 0 ? ARVALID_M0 : ARVALID_M1) && ARREADY_SEL) begin
          m_phase <= 2;
          m_cnt   <= 0;
        end
      end else begin
        if (RVALID_SEL && RREADY_SEL && RLAST_SEL) begin
          m_phase <= 0; m_owner <= -1;
        end
`ifdef AXI_RD_ARB_TIMEOUT_EN
        else if (m_cnt == TB_TO - 1) begin
          m_phase <= 0; m_owner <= -1; m_to <= 1'b1;
        end else begin
          m_cnt <= (RVALID_SEL && RREADY_SEL) ? 0 : m_cnt + 1;
        end
`endif
      end
    end
  end

  always @(negedge ACLK) begin
    if (cmp_en) begin
      chk("model_grant", 32'(grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      chk("model_slave_sel", 32'(slave_sel), (m_owner < 0) ? 32'd6 : 32'(m_sel));
      chk("model_busy", 32'(busy), 32'(m_phase != 0));
      chk("model_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_ar(input int m, input logic [31:0] a);
    if (m == 0) begin ARVALID_M0 = 1'b1; ARADDR_M0 = a; end
    else begin ARVALID_M1 = 1'b1; ARADDR_M1 = a; end
  endtask

  task automatic finish_ar(input int m);
    ARREADY_SEL = 1'b1;
    tick;
    ARREADY_SEL = 1'b0;
    if (m == 0) ARVALID_M0 = 1'b0; else ARVALID_M1 = 1'b0;
  endtask

  task automatic last_beat;
    RVALID_SEL = 1'b1; RREADY_SEL = 1'b1; RLAST_SEL = 1'b1;
    tick;
    RVALID_SEL = 1'b0; RREADY_SEL = 1'b0; RLAST_SEL = 1'b0;
  endtask

  task automatic do_reset;
    ARESETn = 1'b0;
    tick;
    tick;
    ARESETn = 1'b1;
  endtask

  bit          rr_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] bnd_addr [12] = '{32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000, 32'h0002_FFFF,
                                 32'h0003_0000, 32'h1000_03FF, 32'h1000_0400, 32'h1001_0000,
                                 32'h2000_0000, 32'h201F_FFFF, 32'h2020_0000, 32'hFFFF_FFFF};
  int          bnd_sel [12] = '{0, 6, 1, 2, 6, 3, 6, 4, 5, 5, 6, 6};

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got running expected finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 ARESETn = 1'b0;
    #1 cmp_en = 1'b1;
    tick;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_sel", 32'(slave_sel), 32'd6);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    tick;
    ARESETn = 1'b1;

    // Single M0 request, ARREADY on cycle 3, one beat.
    start_ar(0, 32'h0000_0010);
    tick;
    chk("m0_grant", 32'(grant), 32'h1);
    chk("m0_sel", 32'(slave_sel), 32'd0);
    chk("m0_busy", 32'(busy), 32'd1);
    tick;
    tick;
    finish_ar(0);
    chk("m0_data_grant", 32'(grant), 32'h1);
    last_beat;
    chk("m0_done_grant", 32'(grant), 32'd0);
    chk("m0_done_sel", 32'(slave_sel), 32'd6);
    chk("m0_done_busy", 32'(busy), 32'd0);

    // Ties after reset: M0, bubble, M1, then M0 again.
    do_reset;
    start_ar(0, 32'h0001_0000);
    start_ar(1, 32'h0002_0004);
    tick;
    chk("tie1_grant", 32'(grant), 32'h1);
    chk("tie1_sel", 32'(slave_sel), 32'd1);
    finish_ar(0);
    last_beat;
    chk("tie_bubble_grant", 32'(grant), 32'd0);
    chk("tie_bubble_busy", 32'(busy), 32'd0);
    tick;
    chk("tie2_grant", 32'(grant), 32'h2);
    chk("tie2_sel", 32'(slave_sel), 32'd2);
    finish_ar(1);
    last_beat;
    start_ar(0, 32'h0001_0000);
    start_ar(1, 32'h0002_0004);
    tick;
    chk("tie3_grant", 32'(grant), 32'h1);
    finish_ar(0);
    ARVALID_M1 = 1'b0;
    last_beat;

    // Four-beat burst with RREADY stalled once.
    start_ar(0, 32'h1000_0000);
    tick;
    chk("burst_sel", 32'(slave_sel), 32'd3);
    finish_ar(0);
    RVALID_SEL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      RREADY_SEL = rr_pat[i];
      RLAST_SEL  = (i == 4);
      tick;
      chk("burst_grant", 32'(grant), (i < 4) ? 32'h1 : 32'h0);
    end
    RVALID_SEL = 1'b0; RREADY_SEL = 1'b0; RLAST_SEL = 1'b0;

    // Unmapped address from M1.
    start_ar(1, 32'h3000_0000);
    tick;
    chk("unmapped_grant", 32'(grant), 32'h2);
    chk("unmapped_sel", 32'(slave_sel), 32'd6);
    tick;
    finish_ar(1);
    chk("unmapped_busy", 32'(busy), 32'd1);
    last_beat;
    chk("unmapped_done_busy", 32'(busy), 32'd0);

    // Window edges, alternating masters.
    for (int i = 0; i < 12; i++) begin
      start_ar(i % 2, bnd_addr[i]);
      tick;
      chk("edge_sel", 32'(slave_sel), 32'(bnd_sel[i]));
      finish_ar(i % 2);
      last_beat;
    end

    // Asynchronous reset in the middle of a burst.
    start_ar(0, 32'h2000_0100);
    tick;
    finish_ar(0);
    RVALID_SEL = 1'b1; RREADY_SEL = 1'b1;
    tick;
    chk("midburst_grant", 32'(grant), 32'h1);
    #2 ARESETn = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_sel", 32'(slave_sel), 32'd6);
    chk("async_busy", 32'(busy), 32'd0);
    RVALID_SEL = 1'b0; RREADY_SEL = 1'b0;
    tick;
    ARESETn = 1'b1;
    start_ar(0, 32'h0000_0200);
    start_ar(1, 32'h1001_0004);
    tick;
    chk("post_reset_grant", 32'(grant), 32'h1);
    chk("post_reset_sel", 32'(slave_sel), 32'd0);
    finish_ar(0);
    ARVALID_M1 = 1'b0;
    last_beat;

    // No R response after the AR handshake.
    start_ar(1, 32'h0000_0100);
    tick;
    finish_ar(1);
    repeat (TB_TO - 1) tick;
    chk("wait_timeout", 32'(timeout), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    tick;
`ifdef AXI_RD_ARB_TIMEOUT_EN
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_grant", 32'(grant), 32'd0);
    chk("to_sel", 32'(slave_sel), 32'd6);
    tick;
    chk("to_pulse_end", 32'(timeout), 32'd0);
`else
    chk("hold_timeout", 32'(timeout), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_grant", 32'(grant), 32'h2);
    repeat (4) tick;
    last_beat;
    chk("hold_done_busy", 32'(busy), 32'd0);
`endif

    tick;
    tick;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
